// File: rtl/jk_drive_ctrl.sv
// Request-driven controller for a JK flip-flop bank: computes J/K excitation from
// Q feedback, pulses it for one cycle, verifies the result and retries on mismatch.
module jk_drive_ctrl #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic             req_mode,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_q,
    output logic [3:0]       rsp_tries
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_RESP
    } state_t;

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    state_t           state;
    logic [WIDTH-1:0] tgt;
    logic             mode;
    logic [3:0]       tries;
    logic [WIDTH-1:0] mism;

    // Bits already at target produce zero here, so they are held (j=k=0).
    assign mism = q_fb ^ tgt;

    // NOTE: all state and outputs are registered with non-blocking assignments so
    // every branch sees the values from before this edge, never a half-updated mix.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            j         <= '0;
            k         <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_q     <= '0;
            rsp_tries <= '0;
            tgt       <= '0;
            mode      <= 1'b0;
            tries     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    j <= '0;
                    k <= '0;
                    if (req_valid && req_ready) begin
                        tgt       <= req_target;
                        mode      <= req_mode;
                        tries     <= '0;
                        req_ready <= 1'b0;
                        state     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (mode) begin
                        j <= mism;
                        k <= mism;
                    end else begin
                        j <= mism & tgt;
                        k <= mism & ~tgt;
                    end
                    tries <= tries + 4'd1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // The bank samples j/k on the edge that leaves this state.
                    j     <= '0;
                    k     <= '0;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    rsp_q     <= q_fb;
                    rsp_tries <= tries;
                    if (q_fb == tgt) begin
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (tries <= RETRY_LIMIT) begin
                        state <= S_DRIVE;
                    end else begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    j         <= '0;
                    k         <= '0;
                end
            endcase
        end
    end

endmodule
